// File: rtl/draw_source_scheduler.sv
// draw_source_scheduler: per-frame write-bus arbiter granting enabled draw sources in ascending ID order
// Ports: clk, resetN (sync, active-low); frame_start, source_enable in; write_source_sel, write_awaited
// out to the sources; write_active/write_color_data/write_transparent/write_x_addr/write_y_addr bus in;
// fb_we/fb_x/fb_y/fb_data back-buffer write port out; frame_draw_done, busy, frame_overrun, timeout_flags out.
module draw_source_scheduler #(
    parameter int SOURCE_COUNT      = 4,
    parameter int GRANT_TIMEOUT     = 1024,
    parameter int BURST_MAX         = 4096,
    parameter int SOURCE_SEL_ADDRW  = 3,
    parameter int COLOR_DEPTH       = 8,
    parameter int DRAW_WIDTH_ADDRW  = 9,
    parameter int DRAW_HEIGHT_ADDRW = 8,
    parameter int DRAW_WIDTH        = 320,
    parameter int DRAW_HEIGHT       = 240
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    input  logic [SOURCE_COUNT-1:0]      source_enable,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    output logic                         fb_we,
    output logic [DRAW_WIDTH_ADDRW-1:0]  fb_x,
    output logic [DRAW_HEIGHT_ADDRW-1:0] fb_y,
    output logic [COLOR_DEPTH-1:0]       fb_data,
    output logic                         frame_draw_done,
    output logic                         busy,
    output logic                         frame_overrun,
    output logic [SOURCE_COUNT-1:0]      timeout_flags
);
    localparam int WAIT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GRANT_TIMEOUT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX);
    localparam logic [SOURCE_SEL_ADDRW-1:0] SEL_LAST = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);
    localparam logic [DRAW_WIDTH_ADDRW:0] X_LIM = (DRAW_WIDTH_ADDRW + 1)'(DRAW_WIDTH);
    localparam logic [DRAW_HEIGHT_ADDRW:0] Y_LIM = (DRAW_HEIGHT_ADDRW + 1)'(DRAW_HEIGHT);
    typedef enum logic [2:0] {IDLE, SELECT, GRANT, DRAIN, NEXT, DONE} state_t;
    state_t state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic [SOURCE_COUNT-1:0] sel_bit;
    logic en_cur, active, pix_ok;
    assign sel_bit = SOURCE_COUNT'(1) << write_source_sel;
    assign en_cur = |(source_enable & sel_bit);
    // the bus floats outside a grant, so only an explicit 1 counts as a valid pixel
    assign active = (write_active == 1'b1);
    assign pix_ok = !write_transparent && ({1'b0, write_x_addr} < X_LIM) && ({1'b0, write_y_addr} < Y_LIM);
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
            write_source_sel <= '0;
            write_awaited <= 1'b0;
            fb_we <= 1'b0;
            fb_x <= '0;
            fb_y <= '0;
            fb_data <= '0;
            frame_draw_done <= 1'b0;
            busy <= 1'b0;
            frame_overrun <= 1'b0;
            timeout_flags <= '0;
            wait_cnt <= '0;
            burst_cnt <= '0;
        end else begin
            fb_we <= 1'b0;
            frame_draw_done <= 1'b0;
            frame_overrun <= frame_start && (state != IDLE);
            case (state)
                IDLE: if (frame_start) begin
                    state <= SELECT;
                    busy <= 1'b1;
                    write_source_sel <= '0;
                    timeout_flags <= '0;
                    wait_cnt <= '0;
                    burst_cnt <= '0;
                end
                SELECT: begin
                    state <= en_cur ? GRANT : NEXT;
                    write_awaited <= en_cur;
                end
                // timeout has priority over a pixel arriving on the same cycle
                GRANT: if (wait_cnt == WAIT_LAST) begin
                    state <= NEXT;
                    write_awaited <= 1'b0;
                    timeout_flags <= timeout_flags | sel_bit;
                end else if (active) begin
                    state <= DRAIN;
                    burst_cnt <= BURST_W'(1);
                    if (pix_ok) begin
                        fb_we <= 1'b1;
                        fb_x <= write_x_addr;
                        fb_y <= write_y_addr;
                        fb_data <= write_color_data;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                // burst_cnt counts pixels already taken, including the one seen in GRANT
                DRAIN: if (!active) begin
                    state <= NEXT;
                    write_awaited <= 1'b0;
                end else if (burst_cnt == BURST_LAST) begin
                    state <= NEXT;
                    write_awaited <= 1'b0;
                    timeout_flags <= timeout_flags | sel_bit;
                end else begin
                    burst_cnt <= burst_cnt + 1'b1;
                    if (pix_ok) begin
                        fb_we <= 1'b1;
                        fb_x <= write_x_addr;
                        fb_y <= write_y_addr;
                        fb_data <= write_color_data;
                    end
                end
                NEXT: begin
                    wait_cnt <= '0;
                    burst_cnt <= '0;
                    state <= (write_source_sel == SEL_LAST) ? DONE : SELECT;
                    frame_draw_done <= (write_source_sel == SEL_LAST);
                    write_source_sel <= (write_source_sel == SEL_LAST) ? write_source_sel : write_source_sel + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
